// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID and carries control bundle + destination through EX/MEM/WB.
// Generates load-use stalls, honours branch/jump flush, flags illegal instructions, counts stalls.
module pipe_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush_in,
    output logic              stall,
    output logic [14:0]       ex_ctrl,
    output logic [14:0]       mem_ctrl,
    output logic [14:0]       wb_ctrl,
    output logic [REG_AW-1:0] ex_dst,
    output logic [REG_AW-1:0] mem_dst,
    output logic [REG_AW-1:0] wb_dst,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);

    logic [1:0]        reg_dst;
    logic              jump;
    logic              branch;
    logic              mem_read;
    logic [1:0]        mem_reg;
    logic              alu_src;
    logic              reg_write;
    logic              mem_write;
    logic [3:0]        alu_op;
    logic              jump_reg;
    logic              legal;
    logic              uses_rt;
    logic [14:0]       id_ctrl;
    logic [REG_AW-1:0] id_dst;
    logic              load_use;
    logic              advance;

    always_comb begin
        reg_dst   = 2'd0;
        jump      = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_reg   = 2'd0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        alu_op    = 4'd0;
        jump_reg  = 1'b0;
        legal     = 1'b1;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin reg_dst = 2'd1; reg_write = 1'b1; end
                    6'b100010: begin reg_dst = 2'd1; reg_write = 1'b1; alu_op = 4'b0001; end
                    6'b100100: begin reg_dst = 2'd1; reg_write = 1'b1; alu_op = 4'b0010; end
                    6'b100101: begin reg_dst = 2'd1; reg_write = 1'b1; alu_op = 4'b0011; end
                    6'b101010: begin reg_dst = 2'd1; reg_write = 1'b1; alu_op = 4'b0111; end
                    6'b000000: begin
                        reg_dst = 2'd1; alu_src = 1'b1; reg_write = 1'b1; alu_op = 4'b1000;
                    end
                    6'b001000: begin jump = 1'b1; jump_reg = 1'b1; end
                    6'b001001: begin
                        reg_dst = 2'd2; jump = 1'b1; mem_reg = 2'd2; reg_write = 1'b1; jump_reg = 1'b1;
                    end
                    default:   legal = 1'b0;
                endcase
            end
            6'b100011: begin mem_read = 1'b1; mem_reg = 2'd1; alu_src = 1'b1; reg_write = 1'b1; end
            6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'b001000: begin alu_src = 1'b1; reg_write = 1'b1; end
            6'b001100: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 4'b0010; end
            6'b001101: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 4'b0011; end
            6'b001010: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 4'b0111; end
            6'b000100: begin branch = 1'b1; alu_op = 4'b0101; end
            6'b000101: begin branch = 1'b1; alu_op = 4'b0110; end
            6'b000010: jump = 1'b1;
            6'b000011: begin reg_dst = 2'd2; jump = 1'b1; mem_reg = 2'd2; reg_write = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    assign id_ctrl = {jump_reg, reg_dst, jump, branch, mem_read, mem_reg,
                      alu_src, reg_write, mem_write, alu_op};

    always_comb begin
        id_dst = '0;
        if (reg_write) begin
            case (reg_dst)
                2'd0:    id_dst = id_rt;
                2'd1:    id_dst = id_rd;
                default: id_dst = LINK;
            endcase
        end
    end

    // Only R-type, branches and stores actually read rt as a source operand.
    assign uses_rt = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                     (opcode == 6'b000101) || (opcode == 6'b101011);

    assign load_use = id_valid && ex_ctrl[9] && (ex_dst != '0) &&
                      ((ex_dst == id_rs) || ((ex_dst == id_rt) && uses_rt));

    assign stall   = load_use && !flush_in;
    assign advance = id_valid && !flush_in && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl   <= '0;
            mem_ctrl  <= '0;
            wb_ctrl   <= '0;
            ex_dst    <= '0;
            mem_dst   <= '0;
            wb_dst    <= '0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (advance && legal) begin
                ex_ctrl <= id_ctrl;
                ex_dst  <= id_dst;
            end else begin
                ex_ctrl <= '0;
                ex_dst  <= '0;
            end
            mem_ctrl <= ex_ctrl;
            mem_dst  <= ex_dst;
            wb_ctrl  <= mem_ctrl;
            wb_dst   <= mem_dst;
            if (advance && !legal)
                illegal <= 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
